// File: rtl/alu_exec_stage.sv
// Registered MIPS execute stage: ALU decode/compute behind a valid/ready output register.
// Optional iterative unsigned multiplier (multu) is built when ALU_MULT_EN is defined.
module alu_exec_stage #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] se,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result2,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
`ifdef ALU_MULT_EN
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
    localparam int                 CNT_W   = $clog2(WIDTH);
`endif

    typedef enum logic [2:0] {
        K_ADD = 3'd0,
        K_SUB = 3'd1,
        K_AND = 3'd2,
        K_OR  = 3'd3,
        K_SLT = 3'd4,
        K_MUL = 3'd5,
        K_ILL = 3'd6
    } kind_e;

    logic [FUNCT_W-1:0] w_funct;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic               w_lt;
    kind_e              w_kind;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_ovf;
    logic               w_res_ill;
    logic               w_res_zero;
    logic               w_accept;
    logic               w_single_load;
    logic               w_mul_done;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result2;
    logic               r_zero;
    logic               r_ovf;
    logic               r_illegal;

    assign w_funct   = se[FUNCT_W-1:0];
    assign w_b       = alu_src ? se : rd2;
    assign w_sum     = rd1 + w_b;
    assign w_diff    = rd1 - w_b;
    assign w_add_ovf = (rd1[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != rd1[WIDTH-1]);
    assign w_sub_ovf = (rd1[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != rd1[WIDTH-1]);
    // True sign of A-B: the wrapped sign bit flips exactly when the subtraction overflows.
    assign w_lt      = w_diff[WIDTH-1] ^ w_sub_ovf;

    // Decode main-control op and funct into an operation kind.
    always_comb begin
        w_kind = K_ILL;
        case (alu_op)
            2'b00: w_kind = K_ADD;
            2'b01: w_kind = K_SUB;
            2'b10: begin
                if (w_funct == F_ADD) begin
                    w_kind = K_ADD;
                end else if (w_funct == F_SUB) begin
                    w_kind = K_SUB;
                end else if (w_funct == F_AND) begin
                    w_kind = K_AND;
                end else if (w_funct == F_OR) begin
                    w_kind = K_OR;
                end else if (w_funct == F_SLT) begin
                    w_kind = K_SLT;
`ifdef ALU_MULT_EN
                end else if (w_funct == F_MULTU) begin
                    w_kind = K_MUL;
`endif
                end else begin
                    w_kind = K_ILL;
                end
            end
            default: w_kind = K_ILL;
        endcase
    end

    // Single-cycle result, overflow and illegal flags for the decoded kind.
    always_comb begin
        w_res     = {WIDTH{1'b0}};
        w_res_ovf = 1'b0;
        w_res_ill = 1'b0;
        case (w_kind)
            K_ADD: begin
                w_res     = w_sum;
                w_res_ovf = w_add_ovf;
            end
            K_SUB: begin
                w_res     = w_diff;
                w_res_ovf = w_sub_ovf;
            end
            K_AND:   w_res = rd1 & w_b;
            K_OR:    w_res = rd1 | w_b;
            K_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_lt};
            K_MUL:   w_res = {WIDTH{1'b0}};
            default: w_res_ill = 1'b1;
        endcase
    end

    assign w_res_zero    = (w_res == {WIDTH{1'b0}});
    assign w_accept      = in_valid && in_ready;
    assign w_single_load = w_accept && (w_kind != K_MUL);

`ifdef ALU_MULT_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mul_rd2;
    logic [WIDTH-1:0]   r_result_hi;
    logic [2*WIDTH-1:0] w_partial;

    assign w_partial  = r_prod + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    assign w_mul_done = (r_state == S_MUL) && (r_count == CNT_W'(WIDTH-1));
    assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign result_hi  = r_result_hi;

    // Sequencer and shift-add datapath: one multiplier bit per cycle in MUL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= {CNT_W{1'b0}};
            r_mcand   <= {(2*WIDTH){1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_prod    <= {(2*WIDTH){1'b0}};
            r_mul_rd2 <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (w_kind == K_MUL)) begin
                        r_state   <= S_MUL;
                        r_count   <= {CNT_W{1'b0}};
                        r_mcand   <= {{WIDTH{1'b0}}, rd1};
                        r_mplier  <= w_b;
                        r_prod    <= {(2*WIDTH){1'b0}};
                        r_mul_rd2 <= rd2;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_prod   <= w_partial;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (w_mul_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_MUL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_mul_done = 1'b0;
    assign in_ready   = !r_out_valid || out_ready;
    assign result_hi  = {WIDTH{1'b0}};
`endif

    // Output register: load on accept or multiply completion, otherwise hold until drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_result2   <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
`ifdef ALU_MULT_EN
            r_result_hi <= {WIDTH{1'b0}};
`endif
        end else if (w_single_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_result2   <= rd2;
            r_zero      <= w_res_zero;
            r_ovf       <= w_res_ovf;
            r_illegal   <= w_res_ill;
`ifdef ALU_MULT_EN
            r_result_hi <= {WIDTH{1'b0}};
`endif
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
`ifdef ALU_MULT_EN
            r_result    <= w_partial[WIDTH-1:0];
            r_result_hi <= w_partial[2*WIDTH-1:WIDTH];
            r_result2   <= r_mul_rd2;
            r_zero      <= (w_partial == {(2*WIDTH){1'b0}});
`endif
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result2   = r_result2;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign illegal   = r_illegal;

endmodule
